// File: rtl/quad_pkg.sv
// Shared types and the Gray-code transition decoder for the quadrature front end.
// Filter option is selected by the QUAD_FILTER_EN macro in the files that use it.
package quad_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } init_state_e;

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_10 = 2'b10;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_01 = 2'b01;

  typedef struct packed {
    logic valid;
    logic up;
    logic illegal;
  } quad_dec_t;

  // Classifies a {A,B} state change: single-bit change is a step, double-bit is illegal.
  function automatic quad_dec_t quad_dir(input logic [1:0] prev, input logic [1:0] cur);
    quad_dec_t d;
    d = '0;
    if ((prev ^ cur) == 2'b11) begin
      d.illegal = 1'b1;
    end else if (prev != cur) begin
      d.valid = 1'b1;
      case ({prev, cur})
        {PH_00, PH_10}, {PH_10, PH_11}, {PH_11, PH_01}, {PH_01, PH_00}: d.up = 1'b1;
        default: d.up = 1'b0;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/quad_sync_filter.sv
// One encoder channel: metastability synchronizer followed by an optional
// stability filter (enabled by the QUAD_FILTER_EN macro).
module quad_sync_filter
  import quad_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  if (SYNC_STAGES < 2 || FILTER_LEN < 1) begin : g_param_err
    $error("quad_sync_filter: SYNC_STAGES must be >= 2 and FILTER_LEN >= 1");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef QUAD_FILTER_EN
  localparam int CNT_W = $clog2(FILTER_LEN + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             filt_q;

  // Output follows only after FILTER_LEN consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else if (sync_out == filt_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
      cnt_q  <= '0;
      filt_q <= sync_out;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign dout = filt_q;
`else
  assign dout = sync_out;
`endif

endmodule

// File: rtl/quad_decoder.sv
// Quadrature encoder front end: per-channel sync/filter, Gray decode to step/dir,
// illegal-transition flag and saturating counter. Filter enabled by QUAD_FILTER_EN.
module quad_decoder
  import quad_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             enc_a,
  input  logic             enc_b,
  output logic             step,
  output logic             dir,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  output logic [1:0]       phase
);

`ifdef QUAD_FILTER_EN
  localparam int FILL_CYC = SYNC_STAGES + FILTER_LEN;
`else
  localparam int FILL_CYC = SYNC_STAGES;
`endif
  localparam int FILL_W = $clog2(FILL_CYC + 1);

  logic        fa, fb;
  logic [1:0]  cur, prev_q;
  quad_dec_t   dec;

  init_state_e       state_q, state_d;
  logic [FILL_W-1:0] fill_q;
  logic              fill_done;
  logic              load_prev, step_d, err_d;

  quad_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_a (
    .clk(clk), .rst_n(rst_n), .din(enc_a), .dout(fa)
  );

  quad_sync_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_b (
    .clk(clk), .rst_n(rst_n), .din(enc_b), .dout(fb)
  );

  assign cur       = {fa, fb};
  assign dec       = quad_dir(prev_q, cur);
  assign fill_done = (fill_q == FILL_W'(FILL_CYC));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= INIT;
    else        state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (state_q == INIT && fill_done) state_d = RUN;
  end

  // INIT seeds prev once the pipeline holds real pin data, so reset never yields a step.
  always_comb begin
    load_prev = 1'b0;
    step_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      INIT: load_prev = fill_done;
      RUN: begin
        load_prev = 1'b1;
        step_d    = dec.valid;
        err_d     = dec.illegal;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q <= '0;
    end else if (state_q == INIT && !fill_done) begin
      fill_q <= fill_q + FILL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= PH_00;
      step   <= 1'b0;
      err    <= 1'b0;
      dir    <= 1'b0;
    end else begin
      if (load_prev) prev_q <= cur;
      step <= step_d;
      err  <= err_d;
      if (step_d) dir <= dec.up;
    end
  end

  // clr has priority over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (clr) begin
      err_cnt <= '0;
    end else if (err_d && err_cnt != '1) begin
      err_cnt <= err_cnt + ERR_W'(1);
    end
  end

  assign phase = prev_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed, table-driven bench for quad_decoder; expected latency and glitch
// behaviour follow the QUAD_FILTER_EN setting of the build.
module tb_quad_decoder;

  localparam int SYNC  = 2;
  localparam int FLEN  = 4;
  localparam int ERR_W = 8;
`ifdef QUAD_FILTER_EN
  localparam int LAT = SYNC + FLEN + 1;
`else
  localparam int LAT = SYNC + 1;
`endif
  localparam int HOLD = LAT + 5;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             clr   = 1'b0;
  logic             enc_a = 1'b0;
  logic             enc_b = 1'b0;
  logic             step, dir, err;
  logic [ERR_W-1:0] err_cnt;
  logic [1:0]       phase;

  int total = 0;
  int bad   = 0;
  int ns, ne, both, pcyc;

  always #5 clk = ~clk;

  quad_decoder #(.SYNC_STAGES(SYNC), .FILTER_LEN(FLEN), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .enc_a(enc_a), .enc_b(enc_b),
    .step(step), .dir(dir), .err(err), .err_cnt(err_cnt), .phase(phase)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic       a;
    logic       b;
    int         n_step;
    int         n_err;
    logic       exp_dir;
    logic [1:0] exp_phase;
    int         exp_cnt;
  } vec_t;

  vec_t tbl[18];

  task automatic sample_one();
    @(posedge clk);
    #1;
    if (step) ns++;
    if (err) ne++;
    if (step && err) both++;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    ns = 0; ne = 0; both = 0; pcyc = -1;
    @(negedge clk);
    enc_a = v.a;
    enc_b = v.b;
    for (int c = 1; c <= HOLD; c++) begin
      sample_one();
      if ((step || err) && pcyc < 0) pcyc = c;
      if (step) check($sformatf("v%0d_dir_at_step", idx), 32'(dir), 32'(v.exp_dir));
    end
    check($sformatf("v%0d_steps", idx), ns, v.n_step);
    check($sformatf("v%0d_errs", idx), ne, v.n_err);
    check($sformatf("v%0d_overlap", idx), both, 0);
    check($sformatf("v%0d_latency", idx), pcyc, LAT);
    check($sformatf("v%0d_dir", idx), 32'(dir), 32'(v.exp_dir));
    check($sformatf("v%0d_phase", idx), 32'(phase), 32'(v.exp_phase));
    check($sformatf("v%0d_err_cnt", idx), 32'(err_cnt), v.exp_cnt);
  endtask

  task automatic glitch(input int w, input int exp_ns, input string name);
    logic d0, d1;
    d0 = 1'b0; d1 = 1'b0;
    ns = 0; ne = 0;
    @(negedge clk);
    enc_a = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (step) begin
        if (ns == 0) d0 = dir;
        else         d1 = dir;
        ns++;
      end
      if (err) ne++;
      if (c == w) begin
        @(negedge clk);
        enc_a = 1'b0;
      end
    end
    check({name, "_steps"}, ns, exp_ns);
    check({name, "_errs"}, ne, 0);
    check({name, "_phase"}, 32'(phase), 32'(2'b00));
    if (exp_ns == 2) check({name, "_dirs"}, 32'({d0, d1}), 32'(2'b10));
  endtask

  initial begin
    // {a, b, steps, errs, dir, phase, err_cnt}; run starts from phase 11 after reset
    tbl[0]  = '{1'b0, 1'b1, 1, 0, 1'b1, 2'b01, 0};
    tbl[1]  = '{1'b0, 1'b0, 1, 0, 1'b1, 2'b00, 0};
    tbl[2]  = '{1'b1, 1'b0, 1, 0, 1'b1, 2'b10, 0};
    tbl[3]  = '{1'b1, 1'b1, 1, 0, 1'b1, 2'b11, 0};
    tbl[4]  = '{1'b0, 1'b1, 1, 0, 1'b1, 2'b01, 0};
    tbl[5]  = '{1'b0, 1'b0, 1, 0, 1'b1, 2'b00, 0};
    tbl[6]  = '{1'b0, 1'b1, 1, 0, 1'b0, 2'b01, 0};
    tbl[7]  = '{1'b1, 1'b1, 1, 0, 1'b0, 2'b11, 0};
    tbl[8]  = '{1'b1, 1'b0, 1, 0, 1'b0, 2'b10, 0};
    tbl[9]  = '{1'b0, 1'b0, 1, 0, 1'b0, 2'b00, 0};
    tbl[10] = '{1'b1, 1'b0, 1, 0, 1'b1, 2'b10, 0};
    tbl[11] = '{1'b0, 1'b1, 0, 1, 1'b1, 2'b01, 1};
    tbl[12] = '{1'b0, 1'b0, 1, 0, 1'b1, 2'b00, 1};
    tbl[13] = '{1'b1, 1'b1, 0, 1, 1'b1, 2'b11, 2};
    // second run, from phase 00 after the glitch checks, err_cnt cleared
    tbl[14] = '{1'b1, 1'b0, 1, 0, 1'b1, 2'b10, 0};
    tbl[15] = '{1'b0, 1'b1, 0, 1, 1'b1, 2'b01, 1};
    tbl[16] = '{1'b0, 1'b0, 1, 0, 1'b1, 2'b00, 1};
    tbl[17] = '{1'b1, 1'b1, 0, 1, 1'b1, 2'b11, 2};

    // Reset with pins held at 11
    enc_a = 1'b1;
    enc_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_step", 32'(step), 0);
    check("rst_dir", 32'(dir), 0);
    check("rst_err", 32'(err), 0);
    check("rst_err_cnt", 32'(err_cnt), 0);
    check("rst_phase", 32'(phase), 0);
    @(negedge clk);
    rst_n = 1'b1;
    ns = 0; ne = 0; both = 0;
    for (int c = 1; c <= LAT + 10; c++) begin
      sample_one();
      if (c == LAT - 1) check("init_phase_before_load", 32'(phase), 32'(2'b00));
      if (c == LAT)     check("init_phase_loaded", 32'(phase), 32'(2'b11));
    end
    check("init_no_step", ns, 0);
    check("init_no_err", ne, 0);

    for (int i = 0; i < 14; i++) run_vec(tbl[i], i);

    // Saturation: 300 simultaneous A/B toggles starting at 11
    ns = 0; ne = 0; both = 0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      enc_a = ~enc_a;
      enc_b = ~enc_b;
      repeat (6) sample_one();
    end
    repeat (LAT + 3) sample_one();
    check("sat_err_pulses", ne, 300);
    check("sat_no_step", ns, 0);
    check("sat_err_cnt", 32'(err_cnt), 255);
    check("sat_phase", 32'(phase), 32'(2'b11));

    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    check("clr_err_cnt", 32'(err_cnt), 0);

    // clr in the same cycle as an increment: clear wins
    @(negedge clk);
    enc_a = 1'b0;
    enc_b = 1'b0;
    for (int c = 1; c <= LAT + 3; c++) begin
      @(posedge clk);
      #1;
      if (c == LAT - 1) clr = 1'b1;
      if (c == LAT) begin
        check("clrwin_err_pulse", 32'(err), 1);
        check("clrwin_err_cnt", 32'(err_cnt), 0);
        clr = 1'b0;
      end
    end
    check("clrwin_err_cnt_after", 32'(err_cnt), 0);
    check("clrwin_phase", 32'(phase), 32'(2'b00));

`ifdef QUAD_FILTER_EN
    glitch(3, 0, "glitch3");
    glitch(4, 2, "pulse4");
`else
    glitch(1, 2, "glitch1");
`endif

    for (int i = 14; i < 18; i++) run_vec(tbl[i], i);

    // Reset mid-operation at phase 11 with dir=1 and err_cnt=2
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_step", 32'(step), 0);
    check("midrst_err", 32'(err), 0);
    check("midrst_dir", 32'(dir), 0);
    check("midrst_err_cnt", 32'(err_cnt), 0);
    check("midrst_phase", 32'(phase), 0);
    repeat (3) @(posedge clk);
    #1;
    check("midrst_phase_held", 32'(phase), 0);
    @(negedge clk);
    rst_n = 1'b1;
    ns = 0; ne = 0; both = 0;
    repeat (LAT + 13) sample_one();
    check("midrst_no_step", ns, 0);
    check("midrst_no_err", ne, 0);
    check("midrst_phase_after", 32'(phase), 32'(2'b11));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
